// File: rtl/i2s_if.sv
// I2S master/slave link: stereo sample handoff plus the four serial bus wires.
interface i2s_if #(
  parameter int unsigned DATA_BITS = 16
);
  logic signed [DATA_BITS-1:0] in_l;
  logic signed [DATA_BITS-1:0] in_r;
  logic signed [DATA_BITS-1:0] out_l;
  logic signed [DATA_BITS-1:0] out_r;
  logic                        sampled;
  logic                        i2s_sclk;
  logic                        i2s_lrclk;
  logic                        i2s_sdout;
  logic                        i2s_sdin;

  modport master (
    input  in_l, in_r, i2s_sdin,
    output out_l, out_r, sampled, i2s_sclk, i2s_lrclk, i2s_sdout
  );

  modport slave (
    output in_l, in_r, i2s_sdin,
    input  out_l, out_r, sampled, i2s_sclk, i2s_lrclk, i2s_sdout
  );
endinterface

// File: rtl/i2s_master.sv
// I2S bus master: divides sys_clk into sclk/lrclk, shifts a stereo pair out
// in Philips format and captures the returning pair, one frame per strobe.
module i2s_master #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned DATA_BITS = 16
) (
  input logic    sys_clk,
  input logic    rst,
  i2s_if.master  bus
);
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_N   = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0] ONE_B    = BIT_W'(1);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] tx_l, tx_r, rx_l, rx_r;

  logic                 rise_c, fall_c, frame_end_c;
  logic                 lr_nxt_c, sd_nxt_c, rx_en_c;
  logic [BIT_W-1:0]     bit_nxt_c, slot_nxt_c, slot_cur_c;
  logic [IDX_W-1:0]     tx_idx_c, rx_idx_c;
  logic [DATA_BITS-1:0] tx_word_c;

  // Edge decode and the serial bit that goes out on the coming falling edge
  always_comb begin
    rise_c      = (div_cnt == DIV_RISE);
    fall_c      = (div_cnt == DIV_LAST);
    frame_end_c = fall_c && (bit_cnt == BIT_LAST);
    bit_nxt_c   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + ONE_B;
    lr_nxt_c    = (bit_nxt_c >= SLOT_N);
    slot_nxt_c  = lr_nxt_c ? bit_nxt_c - SLOT_N : bit_nxt_c;
    slot_cur_c  = (bit_cnt >= SLOT_N) ? bit_cnt - SLOT_N : bit_cnt;
    tx_word_c   = lr_nxt_c ? tx_r : tx_l;
    tx_idx_c    = IDX_W'(DATA_N - slot_nxt_c);
    rx_idx_c    = IDX_W'(DATA_N - slot_cur_c);
    sd_nxt_c    = 1'b0;
    if (slot_nxt_c >= ONE_B && slot_nxt_c <= DATA_N) begin
      sd_nxt_c = tx_word_c[tx_idx_c];
    end
    rx_en_c     = rise_c && (slot_cur_c >= ONE_B) && (slot_cur_c <= DATA_N);
  end

  // Counters, bus pins and the per-frame sample handoff
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      div_cnt       <= '0;
      bit_cnt       <= '0;
      tx_l          <= '0;
      tx_r          <= '0;
      rx_l          <= '0;
      rx_r          <= '0;
      bus.out_l     <= '0;
      bus.out_r     <= '0;
      bus.sampled   <= 1'b0;
      bus.i2s_sclk  <= 1'b0;
      bus.i2s_lrclk <= 1'b0;
      bus.i2s_sdout <= 1'b0;
    end else begin
      bus.sampled <= 1'b0;
      div_cnt     <= fall_c ? '0 : div_cnt + DIV_W'(1);
      if (rise_c) begin
        bus.i2s_sclk <= 1'b1;
      end
      if (rx_en_c) begin
        if (bus.i2s_lrclk) rx_r[rx_idx_c] <= bus.i2s_sdin;
        else               rx_l[rx_idx_c] <= bus.i2s_sdin;
      end
      if (fall_c) begin
        bus.i2s_sclk  <= 1'b0;
        bit_cnt       <= bit_nxt_c;
        bus.i2s_lrclk <= lr_nxt_c;
        bus.i2s_sdout <= sd_nxt_c;
      end
      // The new frame starts in slot 0, so sdout never sees the freshly loaded tx
      if (frame_end_c) begin
        tx_l        <= bus.in_l;
        tx_r        <= bus.in_r;
        bus.out_l   <= rx_l;
        bus.out_r   <= rx_r;
        bus.sampled <= 1'b1;
      end
    end
  end
endmodule

// File: doc/i2s_master.md
# i2s_master

I2S bus master for the audio path. It generates the bit clock and word clock from `sys_clk`. It serializes a stereo 16-bit sample pair onto the data output and deserializes the stereo pair arriving on the data input. This is the clocking end of the link our existing I2S slave encoder expects, so a codec-less board, or a bench, can drive the slave directly or loop back through it. Samples are handed to and from the DSP chain (reverb, wet/dry) through a once-per-frame `sampled` strobe.

## Interface
Parameters:
- CLK_DIV, 16, `sys_clk` cycles per `i2s_sclk` period. Must be even and ≥4. At 24 MHz this gives a 1.5 MHz `sclk`.
- SLOT_BITS, 32, `sclk` periods per channel slot. Must be ≥ DATA_BITS+1.
- DATA_BITS, 16, sample width.

Ports:
- sys_clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock `sys_clk`
- in_l  in  DATA_BITS  signed left sample to transmit
- in_r  in  DATA_BITS  signed right sample to transmit
- out_l  out  DATA_BITS  signed left sample received
- out_r  out  DATA_BITS  signed right sample received
- sampled  out  1  one-cycle strobe at each frame boundary
- i2s_sclk  out  1  bit clock
- i2s_lrclk  out  1  word select: 0 = left, 1 = right
- i2s_sdout  out  1  serial data to slave
- i2s_sdin  in  1  serial data from slave

## Operation
- Counters:
  - `div_cnt` counts 0..CLK_DIV-1 on every cycle and wraps.
  - `bit_cnt` counts 0..2·SLOT_BITS-1 and advances on the `div_cnt` wrap (the falling `sclk` edge).
  - Channel slot index s = `bit_cnt` mod SLOT_BITS.
- `sclk` generation:
  - Edge with `div_cnt` = CLK_DIV/2-1: `i2s_sclk` ← 1 (rising edge). `i2s_sdin` is sampled on this same edge.
  - Edge with `div_cnt` = CLK_DIV-1: `i2s_sclk` ← 0 (falling edge).
- On the falling edge, `bit_cnt` advances and `i2s_lrclk` and `i2s_sdout` update from the new `bit_cnt`:
  - `lrclk` = (new `bit_cnt` ≥ SLOT_BITS).
  - `sdout` = `tx_word`[DATA_BITS-s] for 1 ≤ s ≤ DATA_BITS; otherwise 0.
  - `tx_word` is `tx_l` in the left slot and `tx_r` in the right slot.
  - This is Philips format: MSB one `sclk` after the `lrclk` transition, MSB first, zero padding.
- Receive: a rising edge in slot s (1 ≤ s ≤ DATA_BITS) writes `i2s_sdin` into bit DATA_BITS-s of `rx_l` or `rx_r`, selected by the current `lrclk`. Other slots are ignored.
- Frame boundary is the falling edge where `bit_cnt` wraps to 0. On that same edge:
  - `tx_l` ← `in_l` and `tx_r` ← `in_r`.
  - `out_l` ← `rx_l` and `out_r` ← `rx_r`.
  - `sampled` ← 1 for exactly one cycle.
- `in_l`/`in_r` changes between boundaries have no effect on the current frame.
- `out_l`/`out_r` are held constant between boundaries.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Reset values:
  - `div_cnt`, `bit_cnt` = 0.
  - `i2s_sclk`, `i2s_lrclk`, `i2s_sdout` = 0.
  - `tx_l`, `tx_r`, `rx_l`, `rx_r`, `out_l`, `out_r` = 0.
  - `sampled` = 0.
- `rst` asserted mid-frame returns everything to reset values on the next edge. There are no partial-frame strobes.
- Timing after reset release, cycle 0 = first cycle with `rst` low (defaults):
  - `sclk` first high at cycle 8; `sclk` period is 16.
  - `bit_cnt` = 1 at cycle 16.
  - `lrclk` rises at cycle 512 and falls at cycle 1024.
  - `sampled` is first high at cycle 1024, then every 1024 cycles (Fs = 23.4375 kHz at 24 MHz).
- The first frame after reset transmits zeros, because `tx` is loaded only at the boundary.
- Transmit latency: `in_*` captured at boundary N is serialized during frame N+1.
- Receive latency: data arriving during frame N appears on `out_*` at boundary N+1, together with `sampled`.
- `sdout` and `lrclk` change only on the `sys_clk` edge that drives `sclk` low, giving half an `sclk` period of setup and hold to the slave's rising-edge sample.

## Test plan
- Reset: hold `rst` for 5 cycles, then release.
  - Outputs are 0 during reset.
  - `sclk` rises at cycle 8; `lrclk` rises at cycle 512.
  - `sampled` pulses for 1 cycle at 1024 and 2048.
- Loopback, `sdin` = `sdout`, with `in_l` = 16'h8001 and `in_r` = 16'h7FFE held constant:
  - At the 1024 boundary, `out` = 0.
  - At the 2048 boundary, `out_l` = 16'h8001 and `out_r` = 16'h7FFE; the values hold thereafter.
- Serial format: with `in_l` = 16'hA5C3, check frame 2:
  - `sdout` bits in left slots 1..16 read 1010_0101_1100_0011.
  - Slot 0 and slots 17..31 are 0.
- Receive from a bench slave model driving 16'h1234 left and 16'hFEDC right (Philips format, changing on falling `sclk`): `out_l` = 16'h1234 and `out_r` = 16'hFEDC at the next boundary.
- Mid-frame input change: switch `in_l` from 16'h0F0F to 16'hF0F0 at cycle 1500. Frame 2 still transmits 16'h0F0F, and frame 3 transmits 16'hF0F0.
- Reset mid-frame: assert `rst` at cycle 1700 for 1 cycle.
  - No `sampled` pulse occurs at 2048.
  - The next `sampled` pulse comes 1024 cycles after release.
  - `out` reads 0 until valid data arrives.
